vdb_hex_display_ctrl: RTL and testbench

//  Parametrised multi-digit 7-segment display controller for virtual-board targets (DE10-Lite HEX0..HEX5).

---
 rtl/vdb_hex_display_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vdb_hex_display_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vdb_hex_display_ctrl.sv
// vdb_hex_display_ctrl
// Multi-digit 7-segment controller. A packed hex value is accepted over a
// valid/ready handshake, decoded one digit per cycle into a staging register
// (MSB first, so leading-zero blanking can be tracked in a single pass), and
// then committed to the display register in one edge so the outputs never
// show a half-written value. The output stage applies PWM brightness,
// per-digit blink and the board's segment polarity.
module vdb_hex_display_ctrl #(
  parameter int DIGITS     = 6,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLK_50,
  input  logic                  RESET_N,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  input  logic [4*DIGITS-1:0]   LOAD_DATA,
  input  logic [DIGITS-1:0]     LOAD_DP,
  input  logic                  BLANK_LZ,
  input  logic [DIGITS-1:0]     BLINK_EN,
  input  logic [PWM_BITS-1:0]   BRIGHTNESS,
  output logic [8*DIGITS-1:0]   HEX
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   IDX_TOP    = IDX_W'(DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [7:0]         OFF_DIGIT  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                state_q;
  logic                  ready_q;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic                  lz_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  nz_q;
  logic [8*DIGITS-1:0]   stage_q;
  logic [8*DIGITS-1:0]   disp_q;

  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BLINK_W-1:0]    blink_cnt_q;
  logic                  phase_q;
  logic [8*DIGITS-1:0]   hex_q;

  logic [3:0]            nib_s;
  logic                  nz_d;
  logic                  blank_s;
  logic [7:0]            dec_byte_d;
  logic                  pwm_on_s;
  logic [8*DIGITS-1:0]   hex_d;

  // Hex nibble to segment pattern, lit = 1, bit order g..a.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Decode of the digit currently addressed by the scan index, with blanking.
  always_comb begin
    nib_s      = data_q[{idx_q, 2'b00} +: 4];
    nz_d       = nz_q | (nib_s != 4'h0);
    blank_s    = lz_q & ~nz_d & (idx_q != '0);
    if (blank_s) begin
      dec_byte_d = {dp_q[idx_q], 7'h00};
    end else begin
      dec_byte_d = {dp_q[idx_q], seg_decode(nib_s)};
    end
  end

  // Load handshake, sequential decode into staging, atomic commit.
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      data_q  <= '0;
      dp_q    <= '0;
      lz_q    <= 1'b0;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      stage_q <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (LOAD_VALID && ready_q) begin
            data_q  <= LOAD_DATA;
            dp_q    <= LOAD_DP;
            lz_q    <= BLANK_LZ;
            idx_q   <= IDX_TOP;
            nz_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          stage_q[{idx_q, 3'b000} +: 8] <= dec_byte_d;
          nz_q <= nz_d;
          if (idx_q == '0) begin
            state_q <= ST_COMMIT;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_COMMIT: begin
          disp_q  <= stage_q;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running PWM counter and blink half-period counter with phase.
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Brightness gate: all-ones duty means always on.
  always_comb begin
    if (BRIGHTNESS == {PWM_BITS{1'b1}}) begin
      pwm_on_s = 1'b1;
    end else begin
      pwm_on_s = (pwm_cnt_q < BRIGHTNESS);
    end
  end

  // Per-digit output gating (PWM, blink) and polarity.
  always_comb begin
    hex_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_d[i*8 +: 8] = (disp_q[i*8 +: 8] &
                         {8{pwm_on_s & ~(phase_q & BLINK_EN[i])}}) ^ OFF_DIGIT;
    end
  end

  // Registered segment outputs.
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      hex_q <= {DIGITS{OFF_DIGIT}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign HEX        = hex_q;
  assign LOAD_READY = ready_q;

endmodule

// File: tb/tb_vdb_hex_display_ctrl.sv
// Bench for vdb_hex_display_ctrl: directed loads feed an expected-value queue,
// and a monitor compares every change of HEX against the queue head.
module tb_vdb_hex_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [23:0] load_data;
  logic [5:0]  load_dp;
  logic        blank_lz;
  logic [5:0]  blink_en;
  logic [3:0]  brightness;
  logic [47:0] hex;

  int          tests;
  int          fails;
  logic [47:0] exp_q[$];
  logic [47:0] exp_v;
  logic [47:0] prev_hex;
  logic        mon_en;

  vdb_hex_display_ctrl #(
    .DIGITS(6), .PWM_BITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .CLK_50(clk), .RESET_N(rst_n), .LOAD_VALID(load_valid), .LOAD_READY(load_ready),
    .LOAD_DATA(load_data), .LOAD_DP(load_dp), .BLANK_LZ(blank_lz),
    .BLINK_EN(blink_en), .BRIGHTNESS(brightness), .HEX(hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every change of HEX must match the next queued display value.
  always @(negedge clk) begin
    if (mon_en && (hex !== prev_hex)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL hex_unexpected: got %h, no update expected", hex);
      end else begin
        exp_v = exp_q.pop_front();
        if (hex !== exp_v) begin
          fails++;
          $display("FAIL hex_update: got %h, expected %h", hex, exp_v);
        end
      end
    end
    prev_hex = hex;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic wait_ready_neg();
    int n = 0;
    @(negedge clk);
    while (load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 48'(load_ready), 48'h1);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic lz,
                         input logic push, input logic [47:0] expv);
    wait_ready_neg();
    load_data  = d;
    load_dp    = dp;
    blank_lz   = lz;
    load_valid = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1 load_valid = 1'b0;
  endtask

  // Count negedges with READY low following a handshake edge.
  task automatic count_low(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (load_ready === 1'b0 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic settle();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain", 48'(exp_q.size()), 48'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          cnt;
    int          cnt2;
    logic [7:0]  d0 [24];
    logic [39:0] rest [24];

    tests = 0; fails = 0; mon_en = 1'b0;
    rst_n = 1'b0; load_valid = 1'b0; load_data = 24'h0; load_dp = 6'h0;
    blank_lz = 1'b0; blink_en = 6'h0; brightness = 4'hF;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_hex", hex, 48'hFFFF_FFFF_FFFF);
    check("reset_ready", 48'(load_ready), 48'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_hex", hex, 48'hFFFF_FFFF_FFFF);
    check("post_reset_ready", 48'(load_ready), 48'h1);
    mon_en = 1'b1;

    // Plain load, no blanking; READY low for 7 cycles
    do_load(24'h012345, 6'h00, 1'b0, 1'b1, 48'hC0F9_A4B0_9992);
    count_low(cnt);
    check("ready_low_cycles", 48'(cnt), 48'd7);
    settle();

    // Decimal points on digits 5 and 0, blanking on but nothing to blank
    do_load(24'hABCDEF, 6'b100001, 1'b1, 1'b1, 48'h0883_C6A1_860E);
    settle();

    // Leading-zero blanking with interior zeros kept
    do_load(24'h000A00, 6'h00, 1'b1, 1'b1, 48'hFFFF_FF88_C0C0);
    settle();

    // All zero with blanking: only digit 0 shows
    do_load(24'h000000, 6'h00, 1'b1, 1'b1, 48'hFFFF_FFFF_FFC0);
    settle();

    // VALID held across two loads
    wait_ready_neg();
    load_data = 24'h987654; load_dp = 6'h00; blank_lz = 1'b0; load_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(48'h9080_F882_9299);
    #1;
    load_data = 24'h000001; load_dp = 6'b100000; blank_lz = 1'b1;
    count_low(cnt);
    check("held_first_low", 48'(cnt), 48'd7);
    @(posedge clk);
    exp_q.push_back(48'h7FFF_FFFF_FFF9);
    #1 load_valid = 1'b0;
    @(negedge clk);
    check("held_second_accepted", 48'(load_ready), 48'h0);
    wait_ready_neg();
    settle();

    // PWM duty 4/16 and zero brightness
    mon_en = 1'b0;
    brightness = 4'h4;
    repeat (2) @(negedge clk);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex[1] == 1'b0) cnt++;
      if (hex[0] == 1'b0) cnt2++;
      @(negedge clk);
    end
    check("pwm4_lit_count", 48'(cnt), 48'd4);
    check("pwm4_unlit_count", 48'(cnt2), 48'd0);
    brightness = 4'h0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex !== 48'hFFFF_FFFF_FFFF) cnt++;
      @(negedge clk);
    end
    check("pwm0_dark", 48'(cnt), 48'd0);

    // Blink digit 0 with half-period 4
    brightness = 4'hF;
    blink_en = 6'b000001;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      d0[i]   = hex[7:0];
      rest[i] = hex[47:8];
      @(negedge clk);
    end
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 24; i++) begin
      if (d0[i] == 8'hFF) cnt++;
      if (d0[i] != 8'hFF && d0[i] != 8'hF9) cnt2++;
      if (rest[i] != 40'h7F_FFFF_FFFF) cnt2++;
      if (i >= 4 && d0[i] == d0[i-4]) cnt2++;
    end
    check("blink_off_count", 48'(cnt), 48'd12);
    check("blink_pattern_errors", 48'(cnt2), 48'd0);
    blink_en = 6'h0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a decode discards the update
    do_load(24'h111111, 6'h00, 1'b0, 1'b0, 48'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_hex", hex, 48'hFFFF_FFFF_FFFF);
    check("midreset_ready", 48'(load_ready), 48'h1);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midreset_discard", hex, 48'hFFFF_FFFF_FFFF);
    check("midreset_ready_after", 48'(load_ready), 48'h1);
    mon_en = 1'b1;

    // Normal operation resumes after the aborted load
    do_load(24'h00C0DE, 6'h00, 1'b1, 1'b1, 48'hFFFF_C6C0_A186);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
